// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, VECTOR layout
// and the offset decoder used by the APB front end.
package irq_ctrl_pkg;

    localparam logic [7:0] OFS_RAW    = 8'h00;
    localparam logic [7:0] OFS_ENABLE = 8'h04;
    localparam logic [7:0] OFS_PEND   = 8'h08;
    localparam logic [7:0] OFS_CLEAR  = 8'h0C;
    localparam logic [7:0] OFS_VECTOR = 8'h10;
    localparam logic [7:0] OFS_SWSET  = 8'h14;

    localparam int VEC_VALID_BIT = 31;
    localparam int VEC_IDX_W     = 5;

    typedef enum logic [2:0] {
        REG_RAW,
        REG_ENABLE,
        REG_PEND,
        REG_CLEAR,
        REG_VECTOR,
        REG_SWSET,
        REG_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_ofs(input logic [7:0] ofs);
        reg_sel_e sel;
        case (ofs)
            OFS_RAW:    sel = REG_RAW;
            OFS_ENABLE: sel = REG_ENABLE;
            OFS_PEND:   sel = REG_PEND;
            OFS_CLEAR:  sel = REG_CLEAR;
            OFS_VECTOR: sel = REG_VECTOR;
            OFS_SWSET:  sel = REG_SWSET;
            default:    sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; reports whether any request is set and
// the index of the lowest one.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]           req_i,
    output logic                   valid_o,
    output logic [VEC_IDX_W-1:0]   idx_o
);

    // Scan downward so the last hit, the lowest index, is the one that sticks.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = VEC_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// APB interrupt controller: rising-edge capture into sticky RAW bits, ENABLE mask,
// lowest-index vector and a registered merged interrupt output.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter logic [11:0] BASE_ADR = 12'h0,
    parameter int          ADR_W    = 32,
    parameter int          DAT_W    = 32,
    parameter int          NUM_IRQ  = 8
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic [ADR_W-1:0]   PADDR,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [DAT_W-1:0]   PWDATA,
    output logic               PREADY,
    output logic [DAT_W-1:0]   PRDATA,
    output logic               PSLVERR,
    input  logic [NUM_IRQ-1:0] IRQ_IN,
    output logic               IRQ_OUT
);

    logic [NUM_IRQ-1:0]   raw_q, raw_d;
    logic [NUM_IRQ-1:0]   en_q, en_d;
    logic [NUM_IRQ-1:0]   irq_d_q;
    logic [DAT_W-1:0]     prdata_q, prdata_d;
    logic                 pslverr_q, pslverr_d;
    logic                 irq_out_q, irq_out_d;

    logic                 blk_sel;
    logic                 mapped;
    logic                 setup_ph;
    logic                 wr_acc;
    reg_sel_e             reg_sel;
    logic [NUM_IRQ-1:0]   wdata_irq;
    logic [NUM_IRQ-1:0]   clr_mask;
    logic [NUM_IRQ-1:0]   set_mask;
    logic [NUM_IRQ-1:0]   rise;
    logic [NUM_IRQ-1:0]   pend;
    logic                 vec_valid;
    logic [VEC_IDX_W-1:0] vec_idx;
    logic [DAT_W-1:0]     rdata;
    logic                 unused_bits;

    assign unused_bits = ^{PADDR, PWDATA};

    assign blk_sel   = PSEL && (PADDR[ADR_W-1:ADR_W-12] == BASE_ADR);
    assign reg_sel   = decode_ofs(PADDR[7:0]);
    assign mapped    = (reg_sel != REG_NONE);
    assign setup_ph  = PSEL && !PENABLE;
    assign wr_acc    = blk_sel && PENABLE && PWRITE && mapped;
    assign wdata_irq = PWDATA[NUM_IRQ-1:0];

    assign clr_mask  = (wr_acc && reg_sel == REG_CLEAR) ? wdata_irq : '0;
    assign set_mask  = (wr_acc && reg_sel == REG_SWSET) ? wdata_irq : '0;
    assign rise      = IRQ_IN & ~irq_d_q;
    assign pend      = raw_q & en_q;

    irq_prio_enc #(
        .N (NUM_IRQ)
    ) u_prio_enc (
        .req_i   (pend),
        .valid_o (vec_valid),
        .idx_o   (vec_idx)
    );

    // Sets are OR-ed in after the clear so a same-cycle set survives.
    always_comb begin
        raw_d = (raw_q & ~clr_mask) | rise | set_mask;
        en_d  = (wr_acc && reg_sel == REG_ENABLE) ? wdata_irq : en_q;
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_RAW:    rdata[NUM_IRQ-1:0] = raw_q;
            REG_ENABLE: rdata[NUM_IRQ-1:0] = en_q;
            REG_PEND:   rdata[NUM_IRQ-1:0] = pend;
            REG_VECTOR: begin
                rdata[VEC_VALID_BIT]   = vec_valid;
                rdata[VEC_IDX_W-1:0]   = vec_idx;
            end
            default:    rdata = '0;
        endcase
    end

    // Read data and error are sampled in the setup phase and held for the access phase.
    always_comb begin
        prdata_d  = prdata_q;
        pslverr_d = 1'b0;
        if (setup_ph) begin
            prdata_d  = (blk_sel && !PWRITE && mapped) ? rdata : '0;
            pslverr_d = blk_sel && !mapped;
        end
        irq_out_d = |pend;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            raw_q     <= '0;
            en_q      <= '0;
            irq_d_q   <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            irq_out_q <= 1'b0;
        end else begin
            raw_q     <= raw_d;
            en_q      <= en_d;
            irq_d_q   <= IRQ_IN;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            irq_out_q <= irq_out_d;
        end
    end

    assign PREADY  = 1'b1;
    assign PRDATA  = prdata_q;
    assign PSLVERR = pslverr_q;
    assign IRQ_OUT = irq_out_q;

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

APB-programmable interrupt controller that consumes the `IRQ` outputs of up to `NUM_IRQ` peripheral blocks (timers first) and merges them into one CPU interrupt line. It sits directly downstream of the timer instances on the same APB bus and PCLK domain. Each line is rising-edge captured into a sticky status bit, masked, and priority-encoded into a vector register.

## Interface
- `BASE_ADR`, 12'h0, block select value compared against `PADDR[ADR_W-1:ADR_W-12]`
- `ADR_W`, 32, APB address width
- `DAT_W`, 32, APB data width
- `NUM_IRQ`, 8, number of interrupt inputs, legal range 1..32

Ports:
- `PCLK`  in  1  single clock
- `PRESET`  in  1  reset, asynchronous, active-high
- `PADDR`  in  ADR_W  APB address; offset is `PADDR[7:0]`
- `PSEL`  in  1  APB select
- `PENABLE`  in  1  APB access phase
- `PWRITE`  in  1  1 = write
- `PWDATA`  in  DAT_W  write data
- `PREADY`  out  1  tied 1, no wait states
- `PRDATA`  out  DAT_W  registered read data
- `PSLVERR`  out  1  error on unmapped offset
- `IRQ_IN`  in  NUM_IRQ  interrupt sources, synchronous to PCLK
- `IRQ_OUT`  out  1  registered merged interrupt

## Operation
- Block is addressed when `PSEL=1` and `PADDR[ADR_W-1:ADR_W-12]==BASE_ADR`.
- Register map:
  - 0x00 RAW (RO): sticky per-line status.
  - 0x04 ENABLE (RW): mask, 1 = enabled.
  - 0x08 PEND (RO): RAW & ENABLE.
  - 0x0C CLEAR (WO): write 1 clears the RAW bit. Reads return 0.
  - 0x10 VECTOR (RO): bit31 = any pending; [4:0] = lowest pending index; 0 when none.
  - 0x14 SWSET (WO): write 1 sets the RAW bit (software trigger). Reads return 0.
- Bits at index ≥ NUM_IRQ: read 0, writes ignored.
- Edge detect: `irq_d` is `IRQ_IN` delayed one cycle. Rise = `IRQ_IN & ~irq_d`. A rise sets RAW. A held-high level sets RAW only once.
- Same-cycle set (rise or SWSET) and CLEAR on one bit: set wins, the bit stays 1.
- Unmapped offset, read or write: `PSLVERR=1` in the access phase, `PRDATA=0`, no state change.

## Timing
- Reset values are all 0: RAW, ENABLE, `irq_d`, `PRDATA`, `PSLVERR`, `IRQ_OUT`.
- An input already high at reset release gives one rise and is captured once.
- Writes take effect at the clock edge ending the access phase (`PSEL&PENABLE&PWRITE`).
- Reads: `PRDATA` is captured in the setup phase (`PSEL&~PENABLE&~PWRITE`) and held through the access phase.
- `PSLVERR` is registered the same way and is valid only in the access phase; it is 0 otherwise.
- `IRQ_IN` rises before edge k: RAW is set at edge k. `IRQ_OUT=|(RAW&ENABLE)` is registered and asserts at edge k+1.
- CLEAR or ENABLE written at edge k: `IRQ_OUT` updates at edge k+1.
- Reset asserted mid-transfer clears everything immediately. The interrupted transfer is lost.

## Structure
- Package `irq_ctrl_pkg` holds:
  - the register offset constants (`OFS_RAW` .. `OFS_SWSET`);
  - the VECTOR valid bit position (31);
  - the vector index width (5).
- Sub-module `irq_prio_enc`: parameterised lowest-index-wins priority encoder, NUM_IRQ in, {valid, index} out. Instantiated once on PEND.
- Top level holds:
  - the APB decode;
  - the RAW, ENABLE and `irq_d` registers;
  - the output registers.

## Test plan
- Reset, then read every register: all 0, `IRQ_OUT=0`, `PSLVERR=0`.
- Write ENABLE=0x05. Pulse `IRQ_IN[2]` for 1 cycle:
  - RAW=0x04 and PEND=0x04;
  - VECTOR=0x8000_0002;
  - `IRQ_OUT` rises one cycle after RAW;
  - write CLEAR=0x04: RAW=0, and `IRQ_OUT` falls one cycle later.
- Hold `IRQ_IN[0]` high, clear bit 0: RAW stays 0 (no re-trigger while the line is held). Drop `IRQ_IN[0]` and raise it again: RAW bit 0 is set.
- ENABLE=0xFF, SWSET=0x88:
  - VECTOR index = 3;
  - CLEAR=0x08: VECTOR index = 7;
  - CLEAR=0x80: VECTOR = 0.
- Rise on `IRQ_IN[1]` in the same cycle as a CLEAR=0x02 access: RAW bit 1 = 1.
- Read offset 0x20 and write offset 0x18: `PSLVERR=1` and `PRDATA=0` in the access phase, no register changes. A read with a mismatched `BASE_ADR` is ignored.
